overlay_blend_pipe: RTL and testbench

Parametrised, pipelined successor to the overlay datapath. It alpha-blends a logo stream, carrying per-pixel alpha packed with its colour, into an AXI4-Stream video stream inside a programmable window. Beyond the previous block it adds:
- N-channel pixels with generic channel and alpha widths;
- correctly normalised and rounded blending, plus a global opacity;
- bypass, blend and colour-key modes;
- frame-start and end-of-line sideband, and line-length error detection.

It sits between the video source and video sink, next to the control register block.

---
 rtl/overlay_blend_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_overlay_blend_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlay_blend_pipe.sv
// Three-stage overlay pipeline: blends a logo stream with per-pixel alpha onto an
// AXI4-Stream video stream inside a programmable window (bypass / blend / colour key).
module overlay_blend_pipe #(
  parameter int CTRL_WIDTH    = 32,
  parameter int CHANNELS      = 4,
  parameter int CHANNEL_WIDTH = 8,
  parameter int ALPHA_WIDTH   = 8,
  localparam int DATA_WIDTH   = CHANNELS * CHANNEL_WIDTH
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              run,
  input  logic [1:0]                        mode,
  input  logic [CTRL_WIDTH-1:0]             width,
  input  logic [CTRL_WIDTH-1:0]             height,
  input  logic [CTRL_WIDTH-1:0]             logo_hbegin,
  input  logic [CTRL_WIDTH-1:0]             logo_hend,
  input  logic [CTRL_WIDTH-1:0]             logo_vbegin,
  input  logic [CTRL_WIDTH-1:0]             logo_vend,
  input  logic [ALPHA_WIDTH-1:0]            global_alpha,
  output logic                              done,
  output logic [CTRL_WIDTH-1:0]             hlocation,
  output logic [CTRL_WIDTH-1:0]             vlocation,
  output logic                              eol_error,
  input  logic [DATA_WIDTH-1:0]             S_AXIS_TDATA_VIDEO,
  input  logic                              S_AXIS_TVALID_VIDEO,
  output logic                              S_AXIS_TREADY_VIDEO,
  input  logic                              S_AXIS_TLAST_VIDEO,
  input  logic                              S_AXIS_TUSER_VIDEO,
  input  logic [DATA_WIDTH+ALPHA_WIDTH-1:0] S_AXIS_TDATA_LOGO,
  input  logic                              S_AXIS_TVALID_LOGO,
  output logic                              S_AXIS_TREADY_LOGO,
  output logic [DATA_WIDTH-1:0]             M_AXIS_TDATA_VIDEO,
  output logic                              M_AXIS_TVALID_VIDEO,
  input  logic                              M_AXIS_TREADY_VIDEO,
  output logic                              M_AXIS_TLAST_VIDEO,
  output logic                              M_AXIS_TUSER_VIDEO
);

  localparam int SUM_W = CHANNEL_WIDTH + ALPHA_WIDTH + 1;
  localparam int PRD_W = 2 * ALPHA_WIDTH;
  localparam int NRM_W = ((SUM_W > PRD_W) ? SUM_W : PRD_W) + 2;
  localparam logic [NRM_W-1:0]       RND    = NRM_W'(1) << (ALPHA_WIDTH - 1);
  localparam logic [ALPHA_WIDTH-1:0] AMAX   = '1;
  localparam logic [NRM_W-1:0]       AMAX_N = NRM_W'(AMAX);
  localparam logic [NRM_W-1:0]       CMAX_N = NRM_W'({CHANNEL_WIDTH{1'b1}});
  localparam logic [CTRL_WIDTH-1:0]  ONE    = CTRL_WIDTH'(1);

  // Rounded division by AMAX without a divider; exact for 8-bit operands.
  function automatic logic [NRM_W-1:0] norm(input logic [NRM_W-1:0] x);
    logic [NRM_W-1:0] t;
    t = x + RND;
    return (t + (t >> ALPHA_WIDTH)) >> ALPHA_WIDTH;
  endfunction

  logic unused_tuser;
  assign unused_tuser = S_AXIS_TUSER_VIDEO;

  logic [CTRL_WIDTH-1:0]  h_cnt, v_cnt;
  logic [1:0]             sh_mode;
  logic [CTRL_WIDTH-1:0]  sh_width, sh_height, sh_hbegin, sh_hend, sh_vbegin, sh_vend;
  logic [ALPHA_WIDTH-1:0] sh_ga;

  // The pixel at (0,0) is the one that loads the shadows, so it sees the live values.
  logic                   at_origin;
  logic [1:0]             cfg_mode;
  logic [CTRL_WIDTH-1:0]  cfg_width, cfg_height, cfg_hbegin, cfg_hend, cfg_vbegin, cfg_vend;
  logic [ALPHA_WIDTH-1:0] cfg_ga;

  assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
  assign cfg_mode   = at_origin ? mode         : sh_mode;
  assign cfg_width  = at_origin ? width        : sh_width;
  assign cfg_height = at_origin ? height       : sh_height;
  assign cfg_hbegin = at_origin ? logo_hbegin  : sh_hbegin;
  assign cfg_hend   = at_origin ? logo_hend    : sh_hend;
  assign cfg_vbegin = at_origin ? logo_vbegin  : sh_vbegin;
  assign cfg_vend   = at_origin ? logo_vend    : sh_vend;
  assign cfg_ga     = at_origin ? global_alpha : sh_ga;

  logic in_win, line_end, frame_end;
  assign in_win = ((cfg_mode == 2'd1) || (cfg_mode == 2'd2)) &&
                  (h_cnt >= cfg_hbegin) && (h_cnt < cfg_hend) &&
                  (v_cnt >= cfg_vbegin) && (v_cnt < cfg_vend);
  assign line_end  = (h_cnt == cfg_width - ONE);
  assign frame_end = line_end && (v_cnt == cfg_height - ONE);

  logic s1_valid, s2_valid, s3_valid;
  logic enable, accept_ok, adv;
  assign enable              = !s3_valid || M_AXIS_TREADY_VIDEO;
  assign accept_ok           = !M_AXI_ARESET && enable && run;
  assign S_AXIS_TREADY_VIDEO = accept_ok && (!in_win || S_AXIS_TVALID_LOGO);
  assign S_AXIS_TREADY_LOGO  = accept_ok && in_win && S_AXIS_TVALID_VIDEO;
  assign adv                 = S_AXIS_TREADY_VIDEO && S_AXIS_TVALID_VIDEO;
  assign hlocation           = h_cnt;
  assign vlocation           = v_cnt;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      h_cnt <= '0; v_cnt <= '0;
      sh_mode <= '0; sh_width <= '0; sh_height <= '0; sh_ga <= '0;
      sh_hbegin <= '0; sh_hend <= '0; sh_vbegin <= '0; sh_vend <= '0;
    end else if (adv) begin
      if (at_origin) begin
        sh_mode <= mode; sh_width <= width; sh_height <= height; sh_ga <= global_alpha;
        sh_hbegin <= logo_hbegin; sh_hend <= logo_hend;
        sh_vbegin <= logo_vbegin; sh_vend <= logo_vend;
      end
      if (!line_end) begin
        h_cnt <= h_cnt + ONE;
      end else begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + ONE;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)                                      eol_error <= 1'b0;
    else if (!run)                                         eol_error <= 1'b0;
    else if (adv && (S_AXIS_TLAST_VIDEO != line_end))      eol_error <= 1'b1;
  end

  // Stage 1: operands and sideband
  logic [DATA_WIDTH-1:0]  s1_video, s1_logo;
  logic [ALPHA_WIDTH-1:0] s1_alpha, s1_ga;
  logic s1_blend, s1_key, s1_last, s1_user, s1_fend;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      s1_valid <= 1'b0; s1_video <= '0; s1_logo <= '0; s1_alpha <= '0; s1_ga <= '0;
      s1_blend <= 1'b0; s1_key <= 1'b0; s1_last <= 1'b0; s1_user <= 1'b0; s1_fend <= 1'b0;
    end else if (enable) begin
      s1_valid <= adv;
      s1_video <= S_AXIS_TDATA_VIDEO;
      s1_logo  <= S_AXIS_TDATA_LOGO[DATA_WIDTH-1:0];
      s1_alpha <= S_AXIS_TDATA_LOGO[DATA_WIDTH +: ALPHA_WIDTH];
      s1_ga    <= cfg_ga;
      s1_blend <= in_win && (cfg_mode == 2'd1);
      s1_key   <= in_win && (cfg_mode == 2'd2);
      s1_last  <= line_end;
      s1_user  <= at_origin;
      s1_fend  <= frame_end;
    end
  end

  // Stage 2: effective alpha and weighted channel sums
  logic [PRD_W-1:0]       a_prod;
  logic [NRM_W-1:0]       a_norm;
  logic [ALPHA_WIDTH-1:0] a_eff, a_inv;
  logic [CHANNELS-1:0][SUM_W-1:0] sum_next, s2_sum;

  always_comb begin
    a_prod   = PRD_W'(s1_alpha) * PRD_W'(s1_ga);
    a_norm   = norm(NRM_W'(a_prod));
    a_eff    = (a_norm > AMAX_N) ? AMAX : a_norm[ALPHA_WIDTH-1:0];
    a_inv    = AMAX - a_eff;
    sum_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_next[c] = SUM_W'(s1_video[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]) * SUM_W'(a_inv) +
                    SUM_W'(s1_logo[c*CHANNEL_WIDTH +: CHANNEL_WIDTH]) * SUM_W'(a_eff);
    end
  end

  logic [DATA_WIDTH-1:0] s2_video, s2_logo;
  logic s2_blend, s2_key_hit, s2_last, s2_user, s2_fend;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      s2_valid <= 1'b0; s2_sum <= '0; s2_video <= '0; s2_logo <= '0;
      s2_blend <= 1'b0; s2_key_hit <= 1'b0; s2_last <= 1'b0; s2_user <= 1'b0; s2_fend <= 1'b0;
    end else if (enable) begin
      s2_valid   <= s1_valid;
      s2_sum     <= sum_next;
      s2_video   <= s1_video;
      s2_logo    <= s1_logo;
      s2_blend   <= s1_blend;
      s2_key_hit <= s1_key && (s1_alpha != '0);
      s2_last    <= s1_last;
      s2_user    <= s1_user;
      s2_fend    <= s1_fend;
    end
  end

  // Stage 3: normalise, saturate, select
  logic [CHANNELS-1:0][NRM_W-1:0] s3_norm;
  logic [DATA_WIDTH-1:0]          blended, out_next;

  always_comb begin
    s3_norm = '0;
    blended = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      s3_norm[c] = norm(NRM_W'(s2_sum[c]));
      blended[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
        (s3_norm[c] > CMAX_N) ? {CHANNEL_WIDTH{1'b1}} : s3_norm[c][CHANNEL_WIDTH-1:0];
    end
    if (s2_blend)        out_next = blended;
    else if (s2_key_hit) out_next = s2_logo;
    else                 out_next = s2_video;
  end

  logic s3_fend;
  assign M_AXIS_TVALID_VIDEO = s3_valid;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      s3_valid <= 1'b0; M_AXIS_TDATA_VIDEO <= '0;
      M_AXIS_TLAST_VIDEO <= 1'b0; M_AXIS_TUSER_VIDEO <= 1'b0; s3_fend <= 1'b0;
    end else if (enable) begin
      s3_valid           <= s2_valid;
      M_AXIS_TDATA_VIDEO <= out_next;
      M_AXIS_TLAST_VIDEO <= s2_last;
      M_AXIS_TUSER_VIDEO <= s2_user;
      s3_fend            <= s2_fend;
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) done <= 1'b0;
    else              done <= s3_valid && M_AXIS_TREADY_VIDEO && s3_fend;
  end

endmodule

// File: tb/tb_overlay_blend_pipe.sv
// Bench for overlay_blend_pipe: constant vectors for blend/key arithmetic plus
// scoreboarded frame sequences (bypass, key, backpressure, starvation, eol, reset).
module tb_overlay_blend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_width, cfg_height, cfg_hb, cfg_he, cfg_vb, cfg_ve;
  logic [7:0]  cfg_ga;
  logic        done, eol_error;
  logic [31:0] hloc, vloc;
  logic [31:0] s_vid_data;
  logic        s_vid_valid, s_vid_ready, s_vid_last, s_vid_user;
  logic [39:0] s_logo_data;
  logic        s_logo_valid, s_logo_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last, m_user;

  overlay_blend_pipe dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .run(run), .mode(cfg_mode),
    .width(cfg_width), .height(cfg_height),
    .logo_hbegin(cfg_hb), .logo_hend(cfg_he), .logo_vbegin(cfg_vb), .logo_vend(cfg_ve),
    .global_alpha(cfg_ga), .done(done), .hlocation(hloc), .vlocation(vloc),
    .eol_error(eol_error),
    .S_AXIS_TDATA_VIDEO(s_vid_data), .S_AXIS_TVALID_VIDEO(s_vid_valid),
    .S_AXIS_TREADY_VIDEO(s_vid_ready), .S_AXIS_TLAST_VIDEO(s_vid_last),
    .S_AXIS_TUSER_VIDEO(s_vid_user),
    .S_AXIS_TDATA_LOGO(s_logo_data), .S_AXIS_TVALID_LOGO(s_logo_valid),
    .S_AXIS_TREADY_LOGO(s_logo_ready),
    .M_AXIS_TDATA_VIDEO(m_data), .M_AXIS_TVALID_VIDEO(m_valid),
    .M_AXIS_TREADY_VIDEO(m_ready), .M_AXIS_TLAST_VIDEO(m_last),
    .M_AXIS_TUSER_VIDEO(m_user)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  md;
    logic [7:0]  ga;
    logic [31:0] vid;
    logic [7:0]  a;
    logic [31:0] lg;
    logic [31:0] xp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    logic        fend;
  } exp_t;

  vec_t  vecs[9];
  exp_t  sb[$];
  int    checks = 0, errors = 0;
  int    cyc = 0, bp_mode = 0;
  int    m_h = 0, m_v = 0;
  int    logo_beats = 0, logo_rdy_seen = 0, done_pulses = 0;
  int    first_adv = -1, first_vld = -1;
  bit    lat_armed = 0, exp_done = 0, prev_stall = 0;
  logic [31:0] held_data;
  logic        held_last, held_user;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_pix(input logic [1:0] md, input logic [7:0] ga,
                                            input logic [31:0] vid, input logic [7:0] a,
                                            input logic [31:0] lg, input bit inw);
    logic [31:0] r;
    int ae, vc, lc;
    if (!inw) return vid;
    if (md == 2'd2) return (a != 8'd0) ? lg : vid;
    ae = (int'(a) * int'(ga) + 127) / 255;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      vc = int'(vid[c*8 +: 8]);
      lc = int'(lg[c*8 +: 8]);
      r[c*8 +: 8] = 8'((vc * (255 - ae) + lc * ae + 127) / 255);
    end
    return r;
  endfunction

  // Moves to 1 time unit after the next rising edge and applies the output-ready pattern.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (bp_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_ready = 1'b0;
    endcase
  endtask

  // Samples at the falling edge; every handshake seen here completes at the next rising edge.
  task automatic sample();
    exp_t e;
    #4;
    if (s_logo_valid && s_logo_ready) logo_beats++;
    if (s_logo_ready) logo_rdy_seen++;
    if (done) done_pulses++;
    if (lat_armed && first_vld < 0 && m_valid) first_vld = cyc;
    chk("done", done, exp_done);
    exp_done = 0;
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, held_data);
      chk("hold_last", m_last, held_last);
      chk("hold_user", m_user, held_user);
    end
    prev_stall = m_valid && !m_ready;
    held_data = m_data; held_last = m_last; held_user = m_user;
    if (m_valid && m_ready) begin
      chk("sb_has_entry", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", m_data, e.data);
        chk("out_last", m_last, e.last);
        chk("out_user", m_user, e.user);
        if (e.fend) exp_done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sample();
      tick();
    end
  endtask

  task automatic send(input logic [31:0] vid, input logic [7:0] a, input logic [31:0] lg,
                      input logic last, input logic lv, input bit has_exp,
                      input logic [31:0] xp);
    exp_t e;
    bit   inw;
    int   n;
    s_vid_data = vid; s_vid_last = last; s_vid_valid = 1'b1;
    s_logo_data = {a, lg}; s_logo_valid = lv;
    n = 0;
    forever begin
      sample();
      if (s_vid_ready) begin
        inw = ((cfg_mode == 2'd1) || (cfg_mode == 2'd2)) &&
              (m_h >= int'(cfg_hb)) && (m_h < int'(cfg_he)) &&
              (m_v >= int'(cfg_vb)) && (m_v < int'(cfg_ve));
        e.data = has_exp ? xp : model_pix(cfg_mode, cfg_ga, vid, a, lg, inw);
        e.last = (m_h == int'(cfg_width) - 1);
        e.user = (m_h == 0) && (m_v == 0);
        e.fend = e.last && (m_v == int'(cfg_height) - 1);
        sb.push_back(e);
        if (lat_armed && first_adv < 0) first_adv = cyc;
        if (m_h < int'(cfg_width) - 1) m_h++;
        else begin
          m_h = 0;
          m_v = (m_v == int'(cfg_height) - 1) ? 0 : m_v + 1;
        end
        tick();
        break;
      end
      tick();
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: no accept after %0d cycles, required accept", n);
        break;
      end
    end
    s_vid_valid = 1'b0; s_logo_valid = 1'b0;
  endtask

  task automatic drain();
    idle(14);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic set_frame(input logic [1:0] md, input int w, input int h, input int hb,
                           input int he, input int vb, input int ve, input logic [7:0] ga);
    cfg_mode = md; cfg_width = 32'(w); cfg_height = 32'(h);
    cfg_hb = 32'(hb); cfg_he = 32'(he); cfg_vb = 32'(vb); cfg_ve = 32'(ve); cfg_ga = ga;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd1, 8'hFF, 32'h00000000, 8'h80, 32'hFFFFFFFF, 32'h80808080};
    vecs[1] = '{2'd1, 8'hFF, 32'h00000000, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{2'd1, 8'hFF, 32'h00000000, 8'h00, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{2'd1, 8'h80, 32'h00000000, 8'hFF, 32'hFFFFFFFF, 32'h80808080};
    vecs[4] = '{2'd1, 8'hFF, 32'h40C08010, 8'h40, 32'h00FF2030, 32'h30D06818};
    vecs[5] = '{2'd2, 8'h00, 32'h12345678, 8'h00, 32'hAABBCCDD, 32'h12345678};
    vecs[6] = '{2'd2, 8'h00, 32'h12345678, 8'h01, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[7] = '{2'd0, 8'hFF, 32'h5A5A5A5A, 8'hFF, 32'hFFFFFFFF, 32'h5A5A5A5A};
    vecs[8] = '{2'd3, 8'hFF, 32'hA5A5A5A5, 8'hFF, 32'hFFFFFFFF, 32'hA5A5A5A5};

    rst = 1'b1; run = 1'b0; m_ready = 1'b1;
    s_vid_data = '0; s_vid_valid = 1'b0; s_vid_last = 1'b0; s_vid_user = 1'b0;
    s_logo_data = '0; s_logo_valid = 1'b0;
    set_frame(2'd0, 1, 1, 0, 1, 0, 1, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    run = 1'b1; s_vid_valid = 1'b1;
    #1;
    chk("rst_tvalid", m_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_eol", eol_error, 0);
    chk("rst_hloc", hloc, 0);
    chk("rst_vid_ready", s_vid_ready, 0);
    s_vid_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single-pixel frames: every pixel is (0,0) and picks up its own configuration.
    foreach (vecs[i]) begin
      set_frame(vecs[i].md, 1, 1, 0, 1, 0, 1, vecs[i].ga);
      send(vecs[i].vid, vecs[i].a, vecs[i].lg, 1'b1, 1'b1, 1'b1, vecs[i].xp);
    end
    drain();

    set_frame(2'd0, 4, 2, 0, 4, 0, 2, 8'hFF);
    logo_rdy_seen = 0; done_pulses = 0;
    for (int i = 0; i < 8; i++)
      send(32'(i + 1), 8'hFF, 32'hFFFFFFFF, (i % 4) == 3, 1'b1, 1'b0, 32'h0);
    drain();
    chk("bypass_logo_ready", logo_rdy_seen, 0);
    chk("bypass_done_pulses", done_pulses, 1);
    chk("bypass_eol", eol_error, 0);

    set_frame(2'd2, 4, 1, 1, 3, 0, 1, 8'h00);
    logo_beats = 0;
    send(32'h11111111, 8'h00, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1, 32'h11111111);
    send(32'h22222222, 8'h00, 32'hBBBBBBBB, 1'b0, 1'b1, 1'b1, 32'h22222222);
    send(32'h33333333, 8'h01, 32'hCCCCCCCC, 1'b0, 1'b1, 1'b1, 32'hCCCCCCCC);
    send(32'h44444444, 8'h01, 32'hDDDDDDDD, 1'b1, 1'b1, 1'b1, 32'h44444444);
    drain();
    chk("key_logo_beats", logo_beats, 2);

    set_frame(2'd1, 16, 4, 3, 12, 1, 3, 8'hC0);
    bp_mode = 1; lat_armed = 1; first_adv = -1; first_vld = -1; logo_beats = 0;
    for (int i = 0; i < 64; i++)
      send($urandom, 8'($urandom), $urandom, (i % 16) == 15, 1'b1, 1'b0, 32'h0);
    drain();
    chk("latency", first_vld - first_adv, 3);
    chk("bp_logo_beats", logo_beats, 18);
    lat_armed = 0; bp_mode = 0;

    set_frame(2'd1, 8, 1, 3, 6, 0, 1, 8'hFF);
    for (int i = 0; i < 3; i++)
      send(32'h01020304 * 32'(i + 1), 8'h80, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 32'h0);
    s_vid_data = 32'h99999999; s_vid_valid = 1'b1; s_vid_last = 1'b0; s_logo_valid = 1'b0;
    repeat (5) begin
      sample();
      chk("starve_vid_ready", s_vid_ready, 0);
      tick();
    end
    chk("starve_hloc", hloc, 3);
    for (int i = 3; i < 8; i++)
      send(32'h10203040 + 32'(i), 8'h60, 32'h0F0F0F0F, i == 7, 1'b1, 1'b0, 32'h0);
    drain();

    set_frame(2'd0, 4, 1, 0, 4, 0, 1, 8'hFF);
    chk("eol_clear", eol_error, 0);
    send(32'hE0, 8'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    send(32'hE1, 8'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    send(32'hE2, 8'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("eol_set", eol_error, 1);
    send(32'hE3, 8'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    drain();
    chk("eol_held", eol_error, 1);
    run = 1'b0; s_vid_valid = 1'b1;
    sample();
    chk("run0_vid_ready", s_vid_ready, 0);
    tick();
    chk("eol_run0_clear", eol_error, 0);
    s_vid_valid = 1'b0; run = 1'b1;
    idle(2);

    set_frame(2'd0, 4, 2, 0, 4, 0, 2, 8'hFF);
    bp_mode = 2; m_ready = 1'b0;
    send(32'hC0, 8'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    send(32'hC1, 8'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", m_valid, 0);
    chk("arst_tdata", m_data, 0);
    chk("arst_tlast", m_last, 0);
    chk("arst_tuser", m_user, 0);
    chk("arst_done", done, 0);
    chk("arst_hloc", hloc, 0);
    chk("arst_vloc", vloc, 0);
    chk("arst_eol", eol_error, 0);
    sb.delete();
    m_h = 0; m_v = 0; prev_stall = 0; exp_done = 0;
    #1;
    rst = 1'b0;
    bp_mode = 0;
    tick();
    for (int i = 0; i < 8; i++)
      send(32'hD0 + 32'(i), 8'h0, 32'h0, (i % 4) == 3, 1'b1, 1'b0, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
